dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data RAM between the pipeline MEM stage (CPU port) and an auxiliary I/O/debug master (IO port).
//  Sits between pipelined_computer_main's MEM stage and the data RAM.
//  CPU has priority; the IO master uses a req/gnt handshake.
//  cpu_stall feeds the pipeline freeze logic, ORed externally with the load-use stall.
// PARAMETERS
//  ADDR_W     32  byte-address width on both master ports
//  DATA_W     32  data word width
//  STARVE_MAX 4   max consecutive cycles IO may be held off by CPU (guard build only), 1..15
// PORTS
//  clock      in   1       system clock; all state updates on its rising edge
//  reset      in   1       synchronous, active-high reset
//  cpu_req    in   1       MEM stage requests an access this cycle
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  byte address
//  cpu_wdata  in   DATA_W  store data
//  cpu_rdata  out  DATA_W  load data, valid cycle after cpu grant
//  cpu_stall  out  1       cpu_req present but not granted this cycle
//  io_req     in   1       IO master request; held with addr/we/wdata stable until io_gnt
//  io_we      in   1       1=write, 0=read
//  io_addr    in   ADDR_W  byte address
//  io_wdata   in   DATA_W  write data
//  io_gnt     out  1       1-cycle pulse: IO access issued this cycle
//  io_rvalid  out  1       1-cycle pulse, cycle after an IO read grant
//  io_rdata   out  DATA_W  read data, qualified by io_rvalid
//  mem_en     out  1       RAM enable
//  mem_we     out  1       RAM write enable
//  mem_addr   out  ADDR_W-2 word address = selected addr[ADDR_W-1:2]
//  mem_wdata  out  DATA_W  RAM write data
//  mem_rdata  in   DATA_W  RAM read data, 1-cycle latency after mem_en
// BEHAVIOUR
//  - Grant decision is combinational per cycle; at most one access issued per cycle.
//  - mem_* are driven combinationally from the winner; mem_en=0, others 0 when idle.
//  - Default rule: cpu_req wins; IO granted only when !cpu_req && io_req.
//  - Owner register states: OWN_NONE, OWN_CPU, OWN_IO_RD, OWN_IO_WR; loaded each cycle with this cycle's grant.
//  - Next cycle: OWN_CPU routes mem_rdata to cpu_rdata; OWN_IO_RD asserts io_rvalid and routes mem_rdata to io_rdata.
//  - cpu_rdata / io_rdata hold their last value when not owner. Writes produce no rvalid.
//  - cpu_stall = cpu_req && !cpu_grant; CPU inputs must stay stable while stalled.
//  - Latency: IO read = grant cycle + 1; uncontended CPU access = 0 stall cycles.
//  - Back-to-back grants to either master allowed; no dead cycle on owner change.
//  - Byte addr[1:0] ignored; word access only.
//  - Reset: owner=OWN_NONE, io_gnt=0, io_rvalid=0, cpu_stall=0, cpu_rdata=0, io_rdata=0, mem_en=0, starve count=0.
//  - Reset asserted with a read outstanding: the pending io_rvalid is cancelled.
//  - io_req dropped before grant: legal; no grant, counter clears.
// CONFIGURATION
//  DMEM_ARB_STARVE_GUARD_EN defined:
//   - 4-bit counter increments each cycle io_req is pending and the CPU wins.
//   - When count==STARVE_MAX, IO wins the next contended cycle: io_gnt=1, cpu_stall=1.
//   - Counter clears on io_gnt or !io_req; saturates, never wraps.
//  Undefined: strict CPU priority, no counter; IO may starve indefinitely.
// STRUCTURE
//  - Package dmem_arb_pkg: owner-state encoding (OWN_*), counter width constant (STARVE_CW=4).
//  - One sub-module, dmem_arb_starve_ctr: guard counter plus force_io output.
//    Instantiated only under DMEM_ARB_STARVE_GUARD_EN; force_io tied 0 otherwise.
// TESTING
//  1. Reset held 3 cycles, then released -> all outputs 0, mem_en=0.
//  2. CPU read 0x10 with RAM[4]=0xDEADBEEF, no IO -> mem_addr=4 same cycle; cpu_rdata=0xDEADBEEF next cycle; cpu_stall=0.
//  3. IO write 0x20=0x1234 with CPU idle -> io_gnt same cycle; RAM[8]=0x1234; io_rvalid stays 0.
//  4. cpu_req held 10 cycles with io read pending -> guard build: io_gnt in cycle 5 with cpu_stall=1 that cycle only;
//     no-guard build: io_gnt only after cpu_req drops.
//  5. IO read granted, reset asserted the next cycle -> io_rvalid=0, owner=OWN_NONE.
//  6. Alternating cpu_req/io_req every cycle -> one grant per cycle, correct rdata routing, no lost or duplicated rvalid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// The owner encoding records which master the RAM served in the previous cycle.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_IO_RD,
        OWN_IO_WR
    } owner_t;

    localparam int unsigned STARVE_CW = 4;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// IO starvation guard: counts cycles the IO master waits behind the CPU, and
// raises force_io once the count reaches STARVE_MAX.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_req,
    input  logic io_req,
    input  logic io_gnt,
    output logic force_io
);

    localparam logic [STARVE_CW-1:0] MAX_CNT = STARVE_CW'(STARVE_MAX);

    logic [STARVE_CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || io_gnt || !io_req) begin
            count <= '0;
        end else if (cpu_req && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign force_io = (count == MAX_CNT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the MEM stage (CPU, priority) and an
// IO/debug master. Define DMEM_ARB_STARVE_GUARD_EN to bound IO starvation.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("dmem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    owner_t            owner_q;
    owner_t            owner_next;
    logic              cpu_grant;
    logic              io_grant;
    logic              force_io;
    logic              cpu_route;
    logic              io_route;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] io_rdata_q;

    // Word access only: the byte offset is deliberately dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{cpu_addr[1:0], io_addr[1:0]};

`ifdef DMEM_ARB_STARVE_GUARD_EN
    dmem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clock   (clock),
        .reset   (reset),
        .cpu_req (cpu_req),
        .io_req  (io_req),
        .io_gnt  (io_grant),
        .force_io(force_io)
    );
`else
    assign force_io = 1'b0;
`endif

    always_comb begin
        io_grant   = !reset && io_req && (!cpu_req || force_io);
        cpu_grant  = !reset && cpu_req && !io_grant;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        owner_next = OWN_NONE;
        if (cpu_grant) begin
            mem_en     = 1'b1;
            mem_we     = cpu_we;
            mem_addr   = cpu_addr[ADDR_W-1:2];
            mem_wdata  = cpu_wdata;
            owner_next = OWN_CPU;
        end else if (io_grant) begin
            mem_en     = 1'b1;
            mem_we     = io_we;
            mem_addr   = io_addr[ADDR_W-1:2];
            mem_wdata  = io_wdata;
            owner_next = io_we ? OWN_IO_WR : OWN_IO_RD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            owner_q <= owner_next;
            if (cpu_route) cpu_rdata_q <= mem_rdata;
            if (io_route)  io_rdata_q  <= mem_rdata;
        end
    end

    // Reset masks the routing so an outstanding IO read never reports rvalid.
    assign cpu_route = !reset && (owner_q == OWN_CPU);
    assign io_route  = !reset && (owner_q == OWN_IO_RD);

    assign cpu_rdata = cpu_route ? mem_rdata : cpu_rdata_q;
    assign io_rdata  = io_route  ? mem_rdata : io_rdata_q;
    assign io_rvalid = io_route;
    assign io_gnt    = io_grant;
    assign cpu_stall = !reset && cpu_req && !cpu_grant;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a 1-cycle-latency RAM model.
// Expectations follow the DMEM_ARB_STARVE_GUARD_EN setting of the build.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              io_req, io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata, io_rdata;
    logic              io_gnt, io_rvalid;
    logic              mem_en, mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] ram [64];

    int n_total = 0;
    int n_pass  = 0;

    dmem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .io_req   (io_req),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_gnt   (io_gnt),
        .io_rvalid(io_rvalid),
        .io_rdata (io_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[5:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : 32'h0000_1234;
    endfunction

    initial begin
        bit          io_done;
        int          prev;
        logic [31:0] prev_addr, exp_cpu, exp_io;

        for (int i = 0; i < 64; i++) ram[i] = 32'hA500_0000 + i;
        ram[4] = 32'hDEADBEEF;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 0;  io_we = 0;  io_addr = '0;  io_wdata = '0;

        // 1: reset
        repeat (3) tick();
        reset = 1'b0;
        #2;
        chk("rst_io_gnt", io_gnt, 0);
        chk("rst_io_rvalid", io_rvalid, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_io_rdata", io_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_owner", 32'(dut.owner_q), 32'(OWN_NONE));

        // 2: uncontended CPU read, byte offset ignored
        tick();
        cpu_req = 1; cpu_addr = 32'h13;
        #2;
        chk("cpu_rd_mem_en", mem_en, 1);
        chk("cpu_rd_mem_we", mem_we, 0);
        chk("cpu_rd_mem_addr", mem_addr, 4);
        chk("cpu_rd_stall", cpu_stall, 0);
        tick();
        cpu_req = 0;
        #2;
        chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_addr", mem_addr, 0);
        tick();
        #2;
        chk("cpu_rd_hold", cpu_rdata, 32'hDEADBEEF);

        // 3: IO write, then read it back
        io_req = 1; io_we = 1; io_addr = 32'h20; io_wdata = 32'h1234;
        #2;
        chk("io_wr_gnt", io_gnt, 1);
        chk("io_wr_mem_we", mem_we, 1);
        chk("io_wr_mem_addr", mem_addr, 8);
        chk("io_wr_mem_wdata", mem_wdata, 32'h1234);
        tick();
        io_req = 0; io_we = 0; io_wdata = '0;
        #2;
        chk("io_wr_no_rvalid", io_rvalid, 0);
        chk("io_wr_ram", ram[8], 32'h1234);
        tick();
        io_req = 1;
        #2;
        chk("io_rd_gnt", io_gnt, 1);
        tick();
        io_req = 0;
        #2;
        chk("io_rd_rvalid", io_rvalid, 1);
        chk("io_rd_data", io_rdata, 32'h1234);
        tick();
        #2;
        chk("io_rd_rvalid_pulse", io_rvalid, 0);
        chk("io_rd_hold", io_rdata, 32'h1234);

        // 4: CPU held 10 cycles against a pending IO read
        io_done = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            cpu_req = 1; cpu_addr = 32'h10;
            io_req = !io_done; io_addr = 32'h10;
            #2;
            chk($sformatf("starve_gnt_c%0d", c), io_gnt, GUARD && c == 5);
            chk($sformatf("starve_stall_c%0d", c), cpu_stall, GUARD && c == 5);
            chk($sformatf("starve_rvalid_c%0d", c), io_rvalid, GUARD && c == 6);
            if (c >= 2) chk($sformatf("starve_cpu_rdata_c%0d", c), cpu_rdata, 32'hDEADBEEF);
            if (GUARD && c == 5) io_done = 1;
        end
        tick();
        cpu_req = 0; io_req = !io_done;
        #2;
        chk("starve_late_gnt", io_gnt, !GUARD);
        tick();
        io_req = 0;
        #2;
        chk("starve_late_rvalid", io_rvalid, !GUARD);
        chk("starve_io_rdata", io_rdata, 32'hDEADBEEF);

        // 4b: IO withdraws mid-wait; guard count restarts from zero
        io_done = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            cpu_req = 1; cpu_addr = 32'h10;
            io_req = !io_done && c != 4; io_addr = 32'h20;
            #2;
            chk($sformatf("clr_gnt_c%0d", c), io_gnt, GUARD && c == 9);
            chk($sformatf("clr_io_rdata_c%0d", c), io_rdata,
                (GUARD && c == 10) ? 32'h1234 : 32'hDEADBEEF);
            if (GUARD && c == 9) io_done = 1;
        end
        tick();
        cpu_req = 0; io_req = !io_done;
        #2;
        chk("clr_late_gnt", io_gnt, !GUARD);
        tick();
        io_req = 0;
        #2;
        chk("clr_final_io_rdata", io_rdata, 32'h1234);

        // 5: reset while an IO read is outstanding
        tick();
        io_req = 1; io_addr = 32'h10;
        #2;
        chk("rst_rd_gnt", io_gnt, 1);
        tick();
        io_req = 0; reset = 1;
        #2;
        chk("rst_rd_rvalid_in_reset", io_rvalid, 0);
        tick();
        reset = 0;
        #2;
        chk("rst_rd_rvalid_after", io_rvalid, 0);
        chk("rst_rd_owner", 32'(dut.owner_q), 32'(OWN_NONE));
        chk("rst_rd_io_rdata", io_rdata, 0);
        chk("rst_rd_cpu_rdata", cpu_rdata, 0);

        // 6: alternating masters, one grant per cycle
        prev = 0; prev_addr = '0; exp_cpu = '0; exp_io = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            cpu_req  = (c % 2 == 0);
            io_req   = (c % 2 == 1);
            cpu_addr = (c % 4 == 0) ? 32'h10 : 32'h20;
            io_addr  = (c % 4 == 1) ? 32'h20 : 32'h10;
            #2;
            if (prev == 1) exp_cpu = word_of(prev_addr);
            if (prev == 2) exp_io  = word_of(prev_addr);
            chk($sformatf("alt_gnt_c%0d", c), io_gnt, c % 2 == 1);
            chk($sformatf("alt_stall_c%0d", c), cpu_stall, 0);
            chk($sformatf("alt_mem_addr_c%0d", c), mem_addr,
                ((c % 2 == 0) ? cpu_addr : io_addr) >> 2);
            chk($sformatf("alt_rvalid_c%0d", c), io_rvalid, prev == 2);
            chk($sformatf("alt_cpu_rdata_c%0d", c), cpu_rdata, exp_cpu);
            chk($sformatf("alt_io_rdata_c%0d", c), io_rdata, exp_io);
            prev      = (c % 2 == 0) ? 1 : 2;
            prev_addr = (c % 2 == 0) ? cpu_addr : io_addr;
        end
        tick();
        cpu_req = 0; io_req = 0;
        #2;
        chk("alt_last_rvalid", io_rvalid, 1);
        chk("alt_last_io_rdata", io_rdata, word_of(prev_addr));
        chk("alt_idle_mem_en", mem_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
